// File: rtl/factor_search_pkg.sv
`default_nettype none
// ============================================================================
// Module   : factor_search_pkg
// Purpose  : Shared types, constants and helpers for the factor search block.
//            - state_t    : FSM state encoding (IDLE, SEARCH, RESP)
//            - FACTOR_ONE : the factor value that is never a legal candidate
//            - next_cand  : candidate successor, skipping the value 1
// Revision : 1.0 - initial release
// ============================================================================
package factor_search_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int unsigned FACTOR_ONE = 1;

    // Successor of a candidate: v+1, except that 0 jumps straight to 2 so the
    // trivial factor 1 is never evaluated.
    function automatic int unsigned next_cand(input int unsigned v);
        return (v == 0) ? 32'd2 : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/factor_pair_check.sv
`default_nettype none
// ============================================================================
// Module   : factor_pair_check
// Purpose  : Combinational test of one candidate pair against a product.
// Ports    : y     in  2W  product being factored
//            x1    in  W   smaller candidate factor
//            x2    in  W   larger candidate factor
//            hit   out 1   x1*x2 == y and neither factor equals 1
//            sq_gt out 1   x1*x1 > y (no larger-x1 pair can still hit)
// Revision : 1.0 - initial release
// ============================================================================
module factor_pair_check
    import factor_search_pkg::*;
#(
    parameter int W = 2
) (
    input  logic [2*W-1:0] y,
    input  logic [W-1:0]   x1,
    input  logic [W-1:0]   x2,
    output logic           hit,
    output logic           sq_gt
);

    localparam logic [W-1:0] c_one = W'(FACTOR_ONE);

    logic [2*W-1:0] w_prod;
    logic [2*W-1:0] w_sq;

    // Zero-extend before multiplying so the product is never truncated.
    assign w_prod = {{W{1'b0}}, x1} * {{W{1'b0}}, x2};
    assign w_sq   = {{W{1'b0}}, x1} * {{W{1'b0}}, x1};

    assign hit   = (w_prod == y) && (x1 != c_one) && (x2 != c_one);
    assign sq_gt = (w_sq > y);

endmodule
`default_nettype wire

// File: rtl/factor_search.sv
`default_nettype none
// ============================================================================
// Module   : factor_search
// Purpose  : Sequential factor generator. Accepts a 2W-bit product and walks
//            candidate pairs (x1 <= x2, neither equal to 1) one per cycle,
//            returning the first pair whose product matches, or not-found.
// Ports    : clk        in  1   clock
//            rst_n      in  1   synchronous active-low reset
//            req_valid  in  1   request present
//            req_ready  out 1   ready for a request (IDLE only)
//            req_y      in  2W  product to factor
//            rsp_valid  out 1   result present (RESP only)
//            rsp_ready  in  1   consumer takes the result
//            rsp_found  out 1   a valid pair was found
//            rsp_x1     out W   smaller factor (0 when not found)
//            rsp_x2     out W   larger factor (0 when not found)
//            busy       out 1   search in progress
// Config   : FACTOR_EARLY_EXIT_EN - when defined, the search ends as soon as
//            x1*x1 exceeds the product (same results, lower latency).
// Revision : 1.0 - initial release
// ============================================================================
module factor_search
    import factor_search_pkg::*;
#(
    parameter int W = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [2*W-1:0] req_y,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_found,
    output logic [W-1:0]   rsp_x1,
    output logic [W-1:0]   rsp_x2,
    output logic           busy
);

    localparam logic [W-1:0] c_max = {W{1'b1}};

    state_t         r_state, w_state_nxt;
    logic [2*W-1:0] r_y,     w_y_nxt;
    logic [W-1:0]   r_x1,    w_x1_nxt;
    logic [W-1:0]   r_x2,    w_x2_nxt;
    logic           r_found, w_found_nxt;
    logic [W-1:0]   r_rx1,   w_rx1_nxt;
    logic [W-1:0]   r_rx2,   w_rx2_nxt;

    logic           w_hit;
    logic           w_sq_gt;
    logic [W-1:0]   w_x1_succ;
    logic [W-1:0]   w_x2_succ;

    factor_pair_check #(
        .W (W)
    ) u_check (
        .y     (r_y),
        .x1    (r_x1),
        .x2    (r_x2),
        .hit   (w_hit),
        .sq_gt (w_sq_gt)
    );

`ifndef FACTOR_EARLY_EXIT_EN
    logic w_unused_sq_gt;
    assign w_unused_sq_gt = w_sq_gt;
`endif

    // Successors never overflow in use: each is only taken while the
    // corresponding register is below its maximum value.
    assign w_x1_succ = W'(next_cand(32'(r_x1)));
    assign w_x2_succ = W'(next_cand(32'(r_x2)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_y     <= '0;
            r_x1    <= '0;
            r_x2    <= '0;
            r_found <= 1'b0;
            r_rx1   <= '0;
            r_rx2   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_y     <= w_y_nxt;
            r_x1    <= w_x1_nxt;
            r_x2    <= w_x2_nxt;
            r_found <= w_found_nxt;
            r_rx1   <= w_rx1_nxt;
            r_rx2   <= w_rx2_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_y_nxt     = r_y;
        w_x1_nxt    = r_x1;
        w_x2_nxt    = r_x2;
        w_found_nxt = r_found;
        w_rx1_nxt   = r_rx1;
        w_rx2_nxt   = r_rx2;

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_y_nxt     = req_y;
                    w_x1_nxt    = '0;
                    w_x2_nxt    = '0;
                    w_state_nxt = SEARCH;
                end
            end

            SEARCH: begin
                if (w_hit) begin
                    w_found_nxt = 1'b1;
                    w_rx1_nxt   = r_x1;
                    w_rx2_nxt   = r_x2;
                    w_state_nxt = RESP;
                end
`ifdef FACTOR_EARLY_EXIT_EN
                else if (w_sq_gt) begin
                    w_found_nxt = 1'b0;
                    w_rx1_nxt   = '0;
                    w_rx2_nxt   = '0;
                    w_state_nxt = RESP;
                end
`endif
                else if ((r_x2 == c_max) && (r_x1 == c_max)) begin
                    w_found_nxt = 1'b0;
                    w_rx1_nxt   = '0;
                    w_rx2_nxt   = '0;
                    w_state_nxt = RESP;
                end else if (r_x2 == c_max) begin
                    // Advance x1 and restart x2 at the new x1 (keeps x1 <= x2).
                    w_x1_nxt = w_x1_succ;
                    w_x2_nxt = w_x1_succ;
                end else begin
                    w_x2_nxt = w_x2_succ;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state == SEARCH);
    assign rsp_valid = (r_state == RESP);
    assign rsp_found = r_found;
    assign rsp_x1    = r_rx1;
    assign rsp_x2    = r_rx2;

endmodule
`default_nettype wire

// File: tb/tb_factor_search.sv
`default_nettype none
// ============================================================================
// Module   : tb_factor_search
// Purpose  : Directed self-checking bench for factor_search at W=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_factor_search;

    localparam int W = 2;

    logic           clk;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic [2*W-1:0] req_y;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_found;
    logic [W-1:0]   rsp_x1;
    logic [W-1:0]   rsp_x2;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    factor_search #(
        .W (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_found (rsp_found),
        .rsp_x1    (rsp_x1),
        .rsp_x2    (rsp_x2),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request with rsp_ready held high; check latency and result.
    task automatic run_req(input logic [3:0] y, input logic f,
                           input logic [1:0] a, input logic [1:0] b,
                           input int k, input string tag);
        int n;
        req_valid = 1'b1;
        req_y     = y;
        rsp_ready = 1'b1;
        tick();                       // accepting edge (edge 0)
        req_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_k"},     n,               k);
        check({tag, "_found"}, 32'(rsp_found),  32'(f));
        check({tag, "_x1"},    32'(rsp_x1),     32'(a));
        check({tag, "_x2"},    32'(rsp_x2),     32'(b));
        tick();                       // handshake edge
        check({tag, "_idle"},  32'(req_ready),  32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_y     = '0;
        rsp_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_found",     32'(rsp_found), 32'd0);
        check("rst_x1",        32'(rsp_x1),    32'd0);
        check("rst_x2",        32'(rsp_x2),    32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        rst_n = 1'b1;
        tick();

        // Order: (0,0) (0,2) (0,3) (2,2) (2,3) (3,3)
        run_req(4'd6, 1'b1, 2'd2, 2'd3, 5, "y6");
        run_req(4'd9, 1'b1, 2'd3, 2'd3, 6, "y9");
        run_req(4'd0, 1'b1, 2'd0, 2'd0, 1, "y0");
`ifdef FACTOR_EARLY_EXIT_EN
        run_req(4'd2, 1'b0, 2'd0, 2'd0, 4, "y2");
`else
        run_req(4'd2, 1'b0, 2'd0, 2'd0, 6, "y2");
`endif
        run_req(4'd5, 1'b0, 2'd0, 2'd0, 6, "y5");

        // Back-pressure on y=4: result held, second request ignored.
        req_valid = 1'b1;
        req_y     = 4'd4;
        rsp_ready = 1'b0;
        tick();
        req_y = 4'd9;                 // stays valid: must be ignored
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_ready", 32'(req_ready), 32'd0);
            check("hold_found", 32'(rsp_found), 32'd1);
            check("hold_x1",    32'(rsp_x1),    32'd2);
            check("hold_x2",    32'(rsp_x2),    32'd2);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("hold_release_valid", 32'(rsp_valid), 32'd0);
        check("hold_release_ready", 32'(req_ready), 32'd1);
        check("hold_release_busy",  32'(busy),      32'd0);

        // Reset mid-search on y=9.
        req_valid = 1'b1;
        req_y     = 4'd9;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check("midrst_busy",  32'(busy),      32'd0);
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd1);
        check("midrst_found", 32'(rsp_found), 32'd0);
        rst_n = 1'b1;
        tick();
        run_req(4'd4, 1'b1, 2'd2, 2'd2, 4, "post_rst_y4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/factor_search.md
# factor_search

Sequential factor generator: accepts a 2W-bit product `y` and searches for an unsigned pair `(x1, x2)` with `x1*x2 == y`, `x1 != 1`, `x2 != 1`, `x1 <= x2`. It returns the first pair found, or a not-found indication. It is the producing counterpart of the combinational factorization checker. Every pair it returns must satisfy that checker, and every `y` the checker can accept must yield `found=1`. The block sits between a request source and a consumer, with valid/ready handshakes on both sides.

## Interface

**Parameters**
- `W`, default 2: factor width in bits. The product is 2W bits.

**Ports**
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `req_y`  in  2W  product to factor; sampled on acceptance.
- `rsp_valid`  out  1  result present; high only in RESP.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_found`  out  1  1 means a valid pair was found.
- `rsp_x1`  out  W  smaller factor; 0 when `rsp_found=0`.
- `rsp_x2`  out  W  larger factor; 0 when `rsp_found=0`.
- `busy`  out  1  high in SEARCH.

## Operation

**States**

IDLE
- `req_ready=1`.
- On `req_valid & req_ready`: latch `y`, set `x1=0`, `x2=0`, go to SEARCH.

SEARCH evaluates one candidate `(x1, x2)` per cycle, with the following priority:
1. Hit (`x1*x2 == y`, neither factor is 1): load `rsp_found=1`, `rsp_x1=x1`, `rsp_x2=x2`; go to RESP.
2. Early exit (only when `FACTOR_EARLY_EXIT_EN` is defined), if `x1*x1 > y`: load `rsp_found=0` and zero factors; go to RESP.
3. `x2 == 2^W-1` and `x1 == 2^W-1`: exhausted; load `rsp_found=0`; go to RESP.
4. `x2 == 2^W-1`: set `x1 = next(x1)`, then `x2 = next(x1)` (that is, `x2` restarts at the new `x1`).
5. Otherwise: `x2 = next(x2)`.

**Rules**
- `next(v)` is `v+1`, except `next(0) = 2`. The value 1 is never a candidate.
- Search order is `x1` ascending, `x2` ascending from `x1`. The first hit therefore has minimal `x1`, then minimal `x2`.
- Products are computed at full 2W width; there is no truncation.
- `y = 0` hits at `(0,0)` on the first cycle.

RESP
- `rsp_*` are held stable until `rsp_valid & rsp_ready`, then the block goes to IDLE.
- `rsp_ready` is ignored outside RESP.
- `req_valid` is ignored outside IDLE; no request is queued.

**Reset**
- `rst_n=0` at an edge forces IDLE from any state, discarding any in-flight search or held result.
- Output values during and after reset: `req_ready=1`, `rsp_valid=0`, `rsp_found=0`, `rsp_x1=0`, `rsp_x2=0`, `busy=0`.

## Timing

- The accepting edge is edge 0. SEARCH evaluates pair k in the cycle after edge k-1.
- `rsp_valid` rises after edge k, where k is the 1-based index of the terminating pair in search order.
- Worst case k for W=2 is 6. In general it is the number of ordered pairs `x1 <= x2` over the non-1 values.
- Minimum RESP dwell is one cycle. A back-to-back request is accepted at the earliest one cycle after the RESP handshake.
- Throughput is one request per (k+2) cycles at best.

## Configuration

- `FACTOR_EARLY_EXIT_EN` defined: the search terminates at the first pair whose `x1*x1 > y`. That terminating cycle is counted in k.
- Not defined: every pair is enumerated until a hit or exhaustion.
- Result values are identical either way; only latency differs.

## Structure

- Package `factor_search_pkg` holds:
  - the state enum (IDLE, SEARCH, RESP);
  - the constant `FACTOR_ONE = 1`;
  - the `next_cand` function.
- Sub-module `factor_pair_check` (combinational) takes inputs `y`, `x1`, `x2` and produces:
  - `hit = (x1*x2 == y) & (x1 != 1) & (x2 != 1)`;
  - `sq_gt = (x1*x1 > y)`.
- The top level holds the FSM, the candidate registers and the output registers.

## Test plan

All scenarios use W=2.
- Accept `y=6` with `rsp_ready=1` → `found=1`, `x1=2`, `x2=3`, `rsp_valid` after edge 5.
- `y=9` → `found=1`, `(3,3)`, k=6.
- `y=0` → `found=1`, `(0,0)`, k=1.
- `y=2`:
  - without the macro: `found=0`, zero factors, k=6;
  - with the macro: `found=0`, k=4.
  - `y=5`: k=6 in both builds.
- Hold `rsp_ready=0` for 3 cycles on `y=4` → `(2,2)` held stable with `rsp_valid=1` and `req_ready=0`; a second `req_valid` is ignored until the handshake completes.
- Assert `rst_n=0` mid-SEARCH on `y=9` → next cycle: IDLE, `busy=0`, `rsp_valid=0`. A subsequent request `y=4` completes normally with `(2,2)`.
